weight_streamer: RTL

- Transmit side of the conv core's 64-bit weight-load interface.
- On a start pulse, reads a packed weight image (kernels, biases, dequant scales, config word) from a fixed-latency source memory.
- Presents each word to the conv core with its byte address and segment tag, using a valid/ready handshake with full backpressure.
- Sits between the weight ROM/BRAM and the conv layer's weight port.

---
 rtl/weight_streamer_pkg.sv | 32 +++
 rtl/weight_sync_fifo.sv | 64 ++++++
 rtl/weight_streamer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/weight_streamer_pkg.sv
// Shared constants and types for the conv-core weight streamer.
// Word counts follow from the conv geometry: 3 in-ch x 24 out-ch x 3x3 taps of
// 8-bit kernels, 24 32-bit biases, 24 64-bit dequant scales and one config word.
package weight_streamer_pkg;

    localparam int unsigned CONV_IN_CH       = 3;
    localparam int unsigned CONV_OUT_CH      = 24;
    localparam int unsigned CONV_KERNEL_TAPS = 9;
    localparam int unsigned WORD_BYTES       = 8;
    localparam int unsigned BIAS_BYTES       = 4;

    localparam int unsigned pKERNEL_NUM        = CONV_IN_CH * CONV_OUT_CH * CONV_KERNEL_TAPS / WORD_BYTES;
    localparam int unsigned pBIAS_NUM          = CONV_OUT_CH * BIAS_BYTES / WORD_BYTES;
    localparam int unsigned pDEQUANT_SCALE_NUM = CONV_OUT_CH;
    localparam int unsigned pWEIGHTS_NUM       = pKERNEL_NUM + pBIAS_NUM + pDEQUANT_SCALE_NUM + 1;
    localparam logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000;

    typedef enum logic [1:0] {
        W_KERNEL = 2'd0,
        W_BIAS   = 2'd1,
        W_SCALE  = 2'd2,
        W_CONFIG = 2'd3
    } weight_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } ws_state_e;

endpackage

// File: rtl/weight_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty flags.
// Ports: clk, rst (sync, active-high), wr_en/wr_data push, rd_en pop,
//        rd_data = head entry, count = occupancy, full, empty.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module weight_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr_c;
    logic             do_rd_c;
    logic [CNT_W-1:0] count_nxt_c;

    // Qualified push/pop and next occupancy
    always_comb begin
        do_wr_c     = wr_en && (!full || rd_en);
        do_rd_c     = rd_en && !empty;
        count_nxt_c = count + CNT_W'(do_wr_c) - CNT_W'(do_rd_c);
    end

    // Storage, pointers and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr_c) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_rd_c) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count_nxt_c;
            full  <= (count_nxt_c == CNT_W'(DEPTH));
            empty <= (count_nxt_c == '0);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/weight_streamer.sv
// Streams the packed weight image from a fixed-latency source memory to the
// conv core's weight port over a valid/ready handshake.
// Ports: clk, rst (sync, active-high); i_start starts a stream, o_busy/o_done
//        report progress; o_rd_en/o_rd_addr/i_rd_data talk to the source
//        memory; o_weight_valid/i_weight_ready/o_weight_addr/o_weight_data/
//        o_weight_type present words to the conv core.
// Reads are issued only while (in-flight + buffered - popping) < pFIFO_DEPTH,
// so returning data always has a FIFO slot and ready may stall indefinitely.
module weight_streamer #(
    parameter int unsigned pWEIGHT_DATA_WIDTH = 64,
    parameter logic [31:0] pWEIGHT_BASE_ADDR  = weight_streamer_pkg::pWEIGHT_BASE_ADDR,
    parameter int unsigned pKERNEL_NUM        = weight_streamer_pkg::pKERNEL_NUM,
    parameter int unsigned pBIAS_NUM          = weight_streamer_pkg::pBIAS_NUM,
    parameter int unsigned pDEQUANT_SCALE_NUM = weight_streamer_pkg::pDEQUANT_SCALE_NUM,
    parameter int unsigned pWEIGHTS_NUM       = weight_streamer_pkg::pWEIGHTS_NUM,
    parameter int unsigned pRD_LATENCY        = 2,
    parameter int unsigned pFIFO_DEPTH        = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_start,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_rd_en,
    output logic [$clog2(pWEIGHTS_NUM)-1:0]   o_rd_addr,
    input  logic [pWEIGHT_DATA_WIDTH-1:0]     i_rd_data,
    output logic                              o_weight_valid,
    input  logic                              i_weight_ready,
    output logic [31:0]                       o_weight_addr,
    output logic [pWEIGHT_DATA_WIDTH-1:0]     o_weight_data,
    output logic [1:0]                        o_weight_type
);

    import weight_streamer_pkg::*;

    localparam int unsigned IDX_W  = $clog2(pWEIGHTS_NUM);
    localparam int unsigned CNT_W  = $clog2(pFIFO_DEPTH + 1);
    localparam int unsigned CRED_W = $clog2(pFIFO_DEPTH + pRD_LATENCY + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pWEIGHTS_NUM - 1);

    ws_state_e                state;
    ws_state_e                state_next;
    logic                     issue_c;
    logic                     start_acc_c;
    logic                     pop_c;
    logic                     push_c;
    logic [CRED_W-1:0]        credit_used_c;
    logic [IDX_W-1:0]         rd_idx;
    logic [IDX_W-1:0]         out_idx;
    logic [IDX_W-1:0]         out_idx_inc_c;
    logic [pRD_LATENCY-1:0]   rd_vld_dl;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;

    // Segment tag of a given output word index
    function automatic weight_type_e type_of(input logic [IDX_W-1:0] idx);
        if (32'(idx) < pKERNEL_NUM)
            return W_KERNEL;
        else if (32'(idx) < pKERNEL_NUM + pBIAS_NUM)
            return W_BIAS;
        else if (32'(idx) < pKERNEL_NUM + pBIAS_NUM + pDEQUANT_SCALE_NUM)
            return W_SCALE;
        else
            return W_CONFIG;
    endfunction

    assign o_weight_valid = !fifo_empty;
    assign pop_c          = o_weight_valid && i_weight_ready;
    assign push_c         = rd_vld_dl[pRD_LATENCY-1];
    assign out_idx_inc_c  = out_idx + IDX_W'(1);

    // Slots committed after this cycle: read on the bus, reads in the delay
    // line and buffered words, less the word leaving this cycle
    always_comb begin
        credit_used_c = CRED_W'(o_rd_en) + CRED_W'(fifo_count);
        for (int i = 0; i < int'(pRD_LATENCY); i++) begin
            credit_used_c = credit_used_c + CRED_W'(rd_vld_dl[i]);
        end
        credit_used_c = credit_used_c - CRED_W'(pop_c);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and read-issue decision for the following cycle
    always_comb begin
        state_next  = state;
        issue_c     = 1'b0;
        start_acc_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    start_acc_c = 1'b1;
                    issue_c     = 1'b1;
                    state_next  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if ((credit_used_c < CRED_W'(pFIFO_DEPTH)) && !(fifo_full && !pop_c)) begin
                    issue_c = 1'b1;
                    if (rd_idx == LAST_IDX) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop_c && (out_idx == LAST_IDX)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered status, read port, rd-valid delay line and output tagging
    always_ff @(posedge clk) begin
        if (rst) begin
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_rd_en       <= 1'b0;
            o_rd_addr     <= '0;
            rd_idx        <= '0;
            rd_vld_dl     <= '0;
            out_idx       <= '0;
            o_weight_addr <= '0;
            o_weight_type <= '0;
        end else begin
            o_busy  <= (state_next == ST_STREAM) || (state_next == ST_DRAIN);
            o_done  <= (state_next == ST_DONE);
            o_rd_en <= issue_c;
            if (issue_c) begin
                o_rd_addr <= rd_idx;
            end
            if (state == ST_DONE) begin
                rd_idx <= '0;
            end else if (issue_c) begin
                rd_idx <= rd_idx + IDX_W'(1);
            end
            rd_vld_dl[0] <= o_rd_en;
            for (int i = 1; i < int'(pRD_LATENCY); i++) begin
                rd_vld_dl[i] <= rd_vld_dl[i-1];
            end
            if (start_acc_c) begin
                out_idx       <= '0;
                o_weight_addr <= pWEIGHT_BASE_ADDR;
                o_weight_type <= W_KERNEL;
            end else if (pop_c) begin
                out_idx       <= out_idx_inc_c;
                o_weight_addr <= pWEIGHT_BASE_ADDR + 32'({out_idx_inc_c, 3'b000});
                o_weight_type <= type_of(out_idx_inc_c);
            end
        end
    end

    weight_sync_fifo #(
        .WIDTH (pWEIGHT_DATA_WIDTH),
        .DEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_c),
        .wr_data (i_rd_data),
        .rd_en   (pop_c),
        .rd_data (o_weight_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
